// File: rtl/dvp_frame_transmitter.sv
// DVP camera-side source: streams RGB565 frame-buffer pixels as an OV7670-style
// vsync/href/byte interface, two bytes per pixel, high byte first.
module dvp_frame_transmitter #(
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int H_BLANK     = 144,
  parameter int VSYNC_LINES = 3,
  parameter int V_BACK      = 17,
  parameter int V_FRONT     = 10,
  parameter int ADDR_W      = 19
) (
  input  logic              pclk,
  input  logic              rst,
  input  logic              enable,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [15:0]       rd_data,
  output logic              vsync,
  output logic              href,
  output logic [7:0]        d,
  output logic              frame_done
);

  localparam int L     = H_BLANK + 2 * H_ACTIVE;
  localparam int HC_W  = $clog2(L);
  localparam int V_M1  = (VSYNC_LINES > V_BACK) ? VSYNC_LINES : V_BACK;
  localparam int V_M2  = (V_ACTIVE > V_FRONT) ? V_ACTIVE : V_FRONT;
  localparam int V_MAX = (V_M1 > V_M2) ? V_M1 : V_M2;
  localparam int VC_W  = (V_MAX > 1) ? $clog2(V_MAX) : 1;
  localparam int NPIX  = H_ACTIVE * V_ACTIVE;
  localparam logic H_BLANK_ODD = (H_BLANK % 2) != 0;

  typedef enum logic [2:0] {IDLE, VS, VBP, ACT, VFP} state_t;

  state_t          state, state_n;
  logic [HC_W-1:0] hcnt, hcnt_n;
  logic [VC_W-1:0] vcnt, vcnt_n;
  logic            line_end, state_end, frame_end;
  logic            vsync_n, href_n, rd_en_n, frame_done_n;
  logic            rd_valid;
  logic [15:0]     pix;

  function automatic logic has_lines(state_t s);
    case (s)
      VS:      return VSYNC_LINES > 0;
      VBP:     return V_BACK > 0;
      ACT:     return V_ACTIVE > 0;
      VFP:     return V_FRONT > 0;
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [VC_W-1:0] last_line(state_t s);
    case (s)
      VS:      return VC_W'(VSYNC_LINES - 1);
      VBP:     return VC_W'(V_BACK - 1);
      ACT:     return VC_W'(V_ACTIVE - 1);
      VFP:     return VC_W'(V_FRONT - 1);
      default: return '0;
    endcase
  endfunction

  // The frame ends in the last vertical region that actually has lines.
  function automatic logic is_last_state(state_t s);
    case (s)
      VFP:     return V_FRONT > 0;
      ACT:     return V_FRONT == 0 && V_ACTIVE > 0;
      VBP:     return V_FRONT == 0 && V_ACTIVE == 0 && V_BACK > 0;
      VS:      return V_FRONT == 0 && V_ACTIVE == 0 && V_BACK == 0;
      default: return 1'b0;
    endcase
  endfunction

  function automatic state_t succ(state_t s);
    case (s)
      VS:      return VBP;
      VBP:     return ACT;
      ACT:     return VFP;
      default: return IDLE;
    endcase
  endfunction

  function automatic state_t skip_empty(state_t s);
    state_t n = s;
    for (int i = 0; i < 4; i++) begin
      if (!has_lines(n)) n = succ(n);
    end
    return n;
  endfunction

  // Outputs are decoded from the next position so they register in step with it.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    state_n   = state;
    hcnt_n    = hcnt;
    vcnt_n    = vcnt;
    line_end  = hcnt == HC_W'(L - 1);
    state_end = line_end && (vcnt == last_line(state));
    frame_end = state_end && is_last_state(state);

    if (state == IDLE) begin
      if (enable) begin
        state_n = skip_empty(VS);
        hcnt_n  = '0;
        vcnt_n  = '0;
      end
    end else if (line_end) begin
      hcnt_n = '0;
      if (state_end) begin
        vcnt_n = '0;
        if (frame_end) state_n = enable ? skip_empty(VS) : IDLE;
        else           state_n = skip_empty(succ(state));
      end else begin
        vcnt_n = vcnt + 1'b1;
      end
    end else begin
      hcnt_n = hcnt + 1'b1;
    end

    vsync_n      = state_n == VS;
    href_n       = (state_n == ACT) && (hcnt_n >= HC_W'(H_BLANK));
    rd_en_n      = (state_n == ACT) && (hcnt_n >= HC_W'(H_BLANK - 2)) &&
                   (hcnt_n <= HC_W'(L - 4)) && (hcnt_n[0] == H_BLANK_ODD);
    frame_done_n = (state_n != IDLE) && (hcnt_n == HC_W'(L - 1)) &&
                   (vcnt_n == last_line(state_n)) && is_last_state(state_n);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      hcnt       <= '0;
      vcnt       <= '0;
      vsync      <= 1'b0;
      href       <= 1'b0;
      rd_en      <= 1'b0;
      rd_addr    <= '0;
      rd_valid   <= 1'b0;
      pix        <= '0;
      d          <= '0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_n;
      hcnt       <= hcnt_n;
      vcnt       <= vcnt_n;
      vsync      <= vsync_n;
      href       <= href_n;
      rd_en      <= rd_en_n;
      frame_done <= frame_done_n;
      rd_valid   <= rd_en;

      if (rd_en) begin
        rd_addr <= (rd_addr == ADDR_W'(NPIX - 1)) ? '0 : rd_addr + 1'b1;
      end else if (state == IDLE) begin
        rd_addr <= '0;
      end

      // High byte comes straight from the returning read; low byte from the hold copy.
      if (rd_valid) pix <= rd_data;
      if (!href_n)       d <= 8'h00;
      else if (rd_valid) d <= rd_data[15:8];
      else               d <= pix[7:0];
    end
  end

endmodule

// File: tb/tb_dvp_frame_transmitter.sv
// Self-checking bench for dvp_frame_transmitter with a small frame geometry
// (L=14, 84-cycle frames) and a frame buffer holding mem[a] = 16'hA000 + a.
module tb_dvp_frame_transmitter;

  localparam int NPIX = 12;
  localparam int TR_N = 90;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        rd_en;
  logic [3:0]  rd_addr;
  logic [15:0] rd_data = 16'h0000;
  logic        vsync, href, frame_done;
  logic [7:0]  d;

  dvp_frame_transmitter #(
    .H_ACTIVE(4), .V_ACTIVE(3), .H_BLANK(6),
    .VSYNC_LINES(1), .V_BACK(1), .V_FRONT(1), .ADDR_W(4)
  ) dut (
    .pclk(clk), .rst(rst), .enable(enable),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .vsync(vsync), .href(href), .d(d), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // Frame buffer: one-cycle read latency.
  always @(posedge clk) begin
    if (rd_en) rd_data <= 16'hA000 + {12'h000, rd_addr};
  end

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  typedef struct {
    logic       vs, hr, re, fd;
    logic [7:0] d;
    logic [3:0] a;
  } trace_t;

  typedef struct {
    int         c;
    logic       vs, hr, re, fd;
    logic [7:0] d;
    logic       ca;
    logic [3:0] a;
  } vec_t;

  // Monitor state
  logic       mon_on = 1'b0;
  logic       arm = 1'b0;
  logic       tracing = 1'b0;
  logic       trace_done = 1'b0;
  logic       vsync_d = 1'b0;
  int         tidx = 0;
  int         cyc = 0;
  int         exp_addr = 0;
  int         vsync_cnt = 0;
  int         href_cnt = 0;
  int         vs_rise_q[$];
  int         fd_q[$];
  logic [7:0] byte_q[$];
  trace_t     tr[TR_N];

  always @(negedge clk) begin
    cyc++;
    if (mon_on) begin
      if (vsync && !vsync_d) begin
        check("frame_start_bytes_left", byte_q.size(), 0);
        byte_q.delete();
        for (int k = 0; k < NPIX; k++) begin
          byte_q.push_back(8'hA0);
          byte_q.push_back(8'(k));
        end
        exp_addr = 0;
        vs_rise_q.push_back(cyc);
        if (arm) begin
          arm = 1'b0;
          tracing = 1'b1;
          tidx = 0;
        end
      end
      if (tracing) begin
        tr[tidx] = '{vsync, href, rd_en, frame_done, d, rd_addr};
        tidx++;
        if (tidx == TR_N) begin
          tracing = 1'b0;
          trace_done = 1'b1;
        end
      end
      if (href) begin
        if (byte_q.size() == 0) check("byte_extra", href, 0);
        else check("d_byte", d, byte_q.pop_front());
      end else begin
        check("d_zero_when_idle", d, 0);
      end
      check("vsync_href_excl", vsync & href, 0);
      if (rd_en) begin
        check("rd_addr", rd_addr, exp_addr);
        exp_addr = (exp_addr + 1) % NPIX;
      end
      if (frame_done) fd_q.push_back(cyc);
      vsync_cnt += int'(vsync);
      href_cnt  += int'(href);
    end
    vsync_d = vsync;
  end

  vec_t vecs[20];

  task automatic run_table(input string pfx);
    for (int i = 0; i < 20; i++) begin
      trace_t t;
      t = tr[vecs[i].c];
      check($sformatf("%s_c%0d_vs_hr_re_fd_d", pfx, vecs[i].c),
            {t.vs, t.hr, t.re, t.fd, t.d},
            {vecs[i].vs, vecs[i].hr, vecs[i].re, vecs[i].fd, vecs[i].d});
      if (vecs[i].ca) check($sformatf("%s_c%0d_rd_addr", pfx, vecs[i].c), t.a, vecs[i].a);
    end
  endtask

  task automatic wait_trace(input string name, input int max);
    for (int i = 0; i < max && !trace_done; i++) tick(1);
    check(name, trace_done, 1);
  endtask

  task automatic check_all_zero(input string pfx);
    check({pfx, "_vsync"}, vsync, 0);
    check({pfx, "_href"}, href, 0);
    check({pfx, "_d"}, d, 0);
    check({pfx, "_rd_en"}, rd_en, 0);
    check({pfx, "_rd_addr"}, rd_addr, 0);
    check({pfx, "_frame_done"}, frame_done, 0);
  endtask

  initial begin
    int n0, nv;
    // Expected samples relative to the first vsync-high cycle of a frame.
    vecs[0]  = '{0,  1, 0, 0, 0, 8'h00, 0, 4'd0};
    vecs[1]  = '{13, 1, 0, 0, 0, 8'h00, 0, 4'd0};
    vecs[2]  = '{14, 0, 0, 0, 0, 8'h00, 0, 4'd0};
    vecs[3]  = '{27, 0, 0, 0, 0, 8'h00, 0, 4'd0};
    vecs[4]  = '{32, 0, 0, 1, 0, 8'h00, 1, 4'd0};
    vecs[5]  = '{33, 0, 0, 0, 0, 8'h00, 0, 4'd0};
    vecs[6]  = '{34, 0, 1, 1, 0, 8'hA0, 1, 4'd1};
    vecs[7]  = '{35, 0, 1, 0, 0, 8'h00, 0, 4'd0};
    vecs[8]  = '{36, 0, 1, 1, 0, 8'hA0, 1, 4'd2};
    vecs[9]  = '{37, 0, 1, 0, 0, 8'h01, 0, 4'd0};
    vecs[10] = '{41, 0, 1, 0, 0, 8'h03, 0, 4'd0};
    vecs[11] = '{42, 0, 0, 0, 0, 8'h00, 0, 4'd0};
    vecs[12] = '{46, 0, 0, 1, 0, 8'h00, 1, 4'd4};
    vecs[13] = '{48, 0, 1, 1, 0, 8'hA0, 1, 4'd5};
    vecs[14] = '{49, 0, 1, 0, 0, 8'h04, 0, 4'd0};
    vecs[15] = '{66, 0, 1, 1, 0, 8'hA0, 1, 4'd11};
    vecs[16] = '{69, 0, 1, 0, 0, 8'h0B, 0, 4'd0};
    vecs[17] = '{70, 0, 0, 0, 0, 8'h00, 0, 4'd0};
    vecs[18] = '{82, 0, 0, 0, 0, 8'h00, 0, 4'd0};
    vecs[19] = '{83, 0, 0, 0, 1, 8'h00, 0, 4'd0};

    rst = 1'b1;
    enable = 1'b0;
    tick(3);
    check_all_zero("reset_hold");

    // Single frame from a one-cycle enable pulse.
    rst = 1'b0;
    tick(2);
    vsync_cnt = 0;
    href_cnt = 0;
    trace_done = 1'b0;
    arm = 1'b1;
    mon_on = 1'b1;
    enable = 1'b1;
    tick(1);
    enable = 1'b0;
    wait_trace("s2_trace_timeout", 400);
    tick(10);
    run_table("s2");
    check("s2_vsync_cycles", vsync_cnt, 14);
    check("s2_href_cycles", href_cnt, 24);
    check("s2_frame_done_count", fd_q.size(), 1);
    if (fd_q.size() >= 1 && vs_rise_q.size() >= 1)
      check("s2_frame_done_offset", fd_q[0] - vs_rise_q[0], 83);
    check("s2_idle_vsync_after", tr[84].vs, 0);
    check("s2_bytes_pending", byte_q.size(), 0);

    // Back-to-back frames with enable held.
    vs_rise_q.delete();
    fd_q.delete();
    enable = 1'b1;
    for (int i = 0; i < 400 && vs_rise_q.size() < 3; i++) tick(1);
    check("s3_frames_seen", vs_rise_q.size() >= 3, 1);
    if (vs_rise_q.size() >= 3) begin
      check("s3_period_1", vs_rise_q[1] - vs_rise_q[0], 84);
      check("s3_period_2", vs_rise_q[2] - vs_rise_q[1], 84);
    end

    // Drop enable during ACT: the frame completes, then the block idles.
    for (int i = 0; i < 100 && !href; i++) tick(1);
    check("s4_reached_act", href, 1);
    enable = 1'b0;
    n0 = fd_q.size();
    nv = vs_rise_q.size();
    for (int i = 0; i < 200 && fd_q.size() == n0; i++) tick(1);
    check("s4_frame_done", fd_q.size(), n0 + 1);
    check("s4_bytes_sent", byte_q.size(), 0);
    tick(150);
    check("s4_no_new_frame", vs_rise_q.size(), nv);
    check("s4_idle_vsync", vsync, 0);
    check("s4_idle_href", href, 0);
    check("s4_single_done", fd_q.size(), n0 + 1);

    // Async reset in the middle of ACT, then release with enable high.
    enable = 1'b1;
    nv = vs_rise_q.size();
    for (int i = 0; i < 200 && vs_rise_q.size() == nv; i++) tick(1);
    for (int i = 0; i < 100 && !href; i++) tick(1);
    check("s5_reached_act", href, 1);
    mon_on = 1'b0;
    rst = 1'b1;
    #1;
    check_all_zero("reset_async");
    tick(2);
    byte_q.delete();
    vs_rise_q.delete();
    fd_q.delete();
    exp_addr = 0;
    trace_done = 1'b0;
    arm = 1'b1;
    mon_on = 1'b1;
    rst = 1'b0;
    wait_trace("s5_trace_timeout", 400);
    run_table("s5");
    enable = 1'b0;
    tick(100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
